// File: rtl/reorder_buffer_if.sv
// Handshake bundle between rename/writeback and the reorder buffer.
// Optional ROB_DEBUG_PC_EN adds per-instruction PC tracing signals.
interface reorder_buffer_if #(
  parameter int IDX_W = 4
);
  logic             alloc1_valid, alloc2_valid;
  logic             alloc1_rf_we, alloc2_rf_we;
  logic [5:0]       alloc1_dest, alloc2_dest;
  logic [5:0]       alloc1_phy_dest, alloc2_phy_dest;
  logic [5:0]       alloc1_old_dest, alloc2_old_dest;
  logic             alloc_ready;
  logic [IDX_W-1:0] alloc1_idx, alloc2_idx;

  logic             wb1_valid, wb2_valid;
  logic [IDX_W-1:0] wb1_idx, wb2_idx;
  logic             wb1_exc, wb2_exc;

  logic             retire_inst1_valid, retire_inst2_valid;
  logic             retire_inst1_rf_we, retire_inst2_rf_we;
  logic [5:0]       retire_inst1_dest, retire_inst2_dest;
  logic [5:0]       retire_inst1_old_dest, retire_inst2_old_dest;
  logic [5:0]       retire_inst1_phy_dest, retire_inst2_phy_dest;
  logic             flush;
  logic             rob_empty;
`ifdef ROB_DEBUG_PC_EN
  logic [31:0]      alloc1_pc, alloc2_pc;
  logic [31:0]      retire_inst1_pc, retire_inst2_pc;
  logic [31:0]      flush_pc;
`endif

  modport master (
    output alloc1_valid, alloc2_valid, alloc1_rf_we, alloc2_rf_we,
           alloc1_dest, alloc2_dest, alloc1_phy_dest, alloc2_phy_dest,
           alloc1_old_dest, alloc2_old_dest,
           wb1_valid, wb2_valid, wb1_idx, wb2_idx, wb1_exc, wb2_exc,
    input  alloc_ready, alloc1_idx, alloc2_idx,
           retire_inst1_valid, retire_inst2_valid, retire_inst1_rf_we, retire_inst2_rf_we,
           retire_inst1_dest, retire_inst2_dest, retire_inst1_old_dest, retire_inst2_old_dest,
           retire_inst1_phy_dest, retire_inst2_phy_dest, flush, rob_empty
`ifdef ROB_DEBUG_PC_EN
    , output alloc1_pc, alloc2_pc
    , input  retire_inst1_pc, retire_inst2_pc, flush_pc
`endif
  );

  modport slave (
    input  alloc1_valid, alloc2_valid, alloc1_rf_we, alloc2_rf_we,
           alloc1_dest, alloc2_dest, alloc1_phy_dest, alloc2_phy_dest,
           alloc1_old_dest, alloc2_old_dest,
           wb1_valid, wb2_valid, wb1_idx, wb2_idx, wb1_exc, wb2_exc,
    output alloc_ready, alloc1_idx, alloc2_idx,
           retire_inst1_valid, retire_inst2_valid, retire_inst1_rf_we, retire_inst2_rf_we,
           retire_inst1_dest, retire_inst2_dest, retire_inst1_old_dest, retire_inst2_old_dest,
           retire_inst1_phy_dest, retire_inst2_phy_dest, flush, rob_empty
`ifdef ROB_DEBUG_PC_EN
    , input  alloc1_pc, alloc2_pc
    , output retire_inst1_pc, retire_inst2_pc, flush_pc
`endif
  );
endinterface

// File: rtl/reorder_buffer.sv
// Two-wide in-order retirement buffer feeding the RAT commit/free-list port.
// Define ROB_DEBUG_PC_EN to carry a PC per entry through to retirement and flush.
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input logic              clk,
  input logic              resetn,
  reorder_buffer_if.slave  rob
);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0]   ptr_t;   // top bit is the wrap flag

  typedef struct packed {
    logic        rf_we;
    logic [5:0]  dest;
    logic [5:0]  phy_dest;
    logic [5:0]  old_dest;
`ifdef ROB_DEBUG_PC_EN
    logic [31:0] pc;
`endif
  } entry_t;

  entry_t           mem [DEPTH];
  logic [DEPTH-1:0] valid, complete, exc;
  ptr_t             head, tail;
  entry_t           ret1, ret2;
  logic             ret1_valid, ret2_valid;
  logic             flush_q;
`ifdef ROB_DEBUG_PC_EN
  logic [31:0]      flush_pc_q;
`endif

  ptr_t   used, free_cnt;
  idx_t   h0, h1, t0, t1;
  logic   r1, r2, x;
  logic   alloc_ready, do_alloc, do_alloc2;
  logic   wb1_ok, wb2_ok;
  entry_t slot1, slot2;

  assign used        = tail - head;
  assign free_cnt    = ptr_t'(DEPTH) - used;
  assign alloc_ready = (free_cnt >= ptr_t'(2)) && !flush_q;

  assign h0 = head[IDX_W-1:0];
  assign h1 = h0 + idx_t'(1);
  assign t0 = tail[IDX_W-1:0];
  assign t1 = t0 + idx_t'(1);

  // Retirement is decided purely from registered state.
  assign r1 = valid[h0] & complete[h0] & ~exc[h0];
  assign r2 = r1 & valid[h1] & complete[h1] & ~exc[h1];
  assign x  = valid[h0] & complete[h0] & exc[h0];

  assign do_alloc  = alloc_ready & rob.alloc1_valid & ~x;
  assign do_alloc2 = do_alloc & rob.alloc2_valid;
  assign wb1_ok    = ~flush_q & ~x & rob.wb1_valid & valid[rob.wb1_idx];
  assign wb2_ok    = ~flush_q & ~x & rob.wb2_valid & valid[rob.wb2_idx];

  // NOTE: every field gets a default before the selective assignments, so no latch is inferred.
  always_comb begin
    slot1          = '0;
    slot1.rf_we    = rob.alloc1_rf_we;
    slot1.dest     = rob.alloc1_dest;
    slot1.phy_dest = rob.alloc1_phy_dest;
    slot1.old_dest = rob.alloc1_old_dest;
    slot2          = '0;
    slot2.rf_we    = rob.alloc2_rf_we;
    slot2.dest     = rob.alloc2_dest;
    slot2.phy_dest = rob.alloc2_phy_dest;
    slot2.old_dest = rob.alloc2_old_dest;
`ifdef ROB_DEBUG_PC_EN
    slot1.pc       = rob.alloc1_pc;
    slot2.pc       = rob.alloc2_pc;
`endif
  end

  // NOTE: non-blocking assignments throughout so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head       <= '0;
      tail       <= '0;
      valid      <= '0;
      complete   <= '0;
      exc        <= '0;
      ret1       <= '0;
      ret2       <= '0;
      ret1_valid <= 1'b0;
      ret2_valid <= 1'b0;
      flush_q    <= 1'b0;
`ifdef ROB_DEBUG_PC_EN
      flush_pc_q <= '0;
`endif
    end else begin
      flush_q    <= x;
      ret1_valid <= r1;
      ret2_valid <= r2;
      ret1       <= r1 ? mem[h0] : '0;
      ret2       <= r2 ? mem[h1] : '0;
`ifdef ROB_DEBUG_PC_EN
      flush_pc_q <= x ? mem[h0].pc : '0;
`endif
      if (x) begin
        // Excepting head: discard everything, including this cycle's alloc/wb.
        valid    <= '0;
        complete <= '0;
        exc      <= '0;
        head     <= '0;
        tail     <= '0;
      end else begin
        if (wb1_ok) begin
          complete[rob.wb1_idx] <= 1'b1;
          if (rob.wb1_exc) exc[rob.wb1_idx] <= 1'b1;
        end
        if (wb2_ok) begin
          complete[rob.wb2_idx] <= 1'b1;
          if (rob.wb2_exc) exc[rob.wb2_idx] <= 1'b1;
        end
        if (r1) valid[h0] <= 1'b0;
        if (r2) valid[h1] <= 1'b0;
        head <= head + ptr_t'(r1) + ptr_t'(r2);
        if (do_alloc) begin
          valid[t0]    <= 1'b1;
          complete[t0] <= 1'b0;
          exc[t0]      <= 1'b0;
          if (do_alloc2) begin
            valid[t1]    <= 1'b1;
            complete[t1] <= 1'b0;
            exc[t1]      <= 1'b0;
          end
          tail <= tail + (do_alloc2 ? ptr_t'(2) : ptr_t'(1));
        end
      end
    end
  end

  // NOTE: payload storage has no reset; it is only observed through the reset valid bits.
  always_ff @(posedge clk) begin
    if (do_alloc)  mem[t0] <= slot1;
    if (do_alloc2) mem[t1] <= slot2;
  end

  assign rob.alloc_ready           = alloc_ready;
  assign rob.alloc1_idx            = t0;
  assign rob.alloc2_idx            = t1;
  assign rob.retire_inst1_valid    = ret1_valid;
  assign rob.retire_inst1_rf_we    = ret1.rf_we;
  assign rob.retire_inst1_dest     = ret1.dest;
  assign rob.retire_inst1_phy_dest = ret1.phy_dest;
  assign rob.retire_inst1_old_dest = ret1.old_dest;
  assign rob.retire_inst2_valid    = ret2_valid;
  assign rob.retire_inst2_rf_we    = ret2.rf_we;
  assign rob.retire_inst2_dest     = ret2.dest;
  assign rob.retire_inst2_phy_dest = ret2.phy_dest;
  assign rob.retire_inst2_old_dest = ret2.old_dest;
  assign rob.flush                 = flush_q;
  assign rob.rob_empty             = (head == tail);
`ifdef ROB_DEBUG_PC_EN
  assign rob.retire_inst1_pc       = ret1.pc;
  assign rob.retire_inst2_pc       = ret2.pc;
  assign rob.flush_pc              = flush_pc_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: allocations push expected retirements in
// program order, a negedge monitor pops and compares every retire slot.
module tb_reorder_buffer;

  typedef struct packed {
    logic       rf_we;
    logic [5:0] dest;
    logic [5:0] phy;
    logic [5:0] old;
  } ins_t;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  reorder_buffer_if #(.IDX_W(4)) rob ();
  reorder_buffer #(.DEPTH(16), .IDX_W(4)) dut (.clk(clk), .resetn(resetn), .rob(rob));

  int   checks = 0;
  int   errors = 0;
  ins_t exp_q[$];    // expected retirements, program order
  int   pending[$];  // allocated but not yet written back
  int   m_tail;      // model allocation counter

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ins_t mk(input bit we, input int d, input int p, input int o);
    ins_t r;
    r.rf_we = we; r.dest = 6'(d); r.phy = 6'(p); r.old = 6'(o);
    return r;
  endfunction

  function automatic ins_t rnd_ins();
    return mk(1'($urandom_range(0, 1)), $urandom_range(0, 33), $urandom_range(0, 63), $urandom_range(0, 63));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rob.alloc1_valid = 0; rob.alloc2_valid = 0;
    rob.alloc1_rf_we = 0; rob.alloc2_rf_we = 0;
    rob.alloc1_dest = 0; rob.alloc2_dest = 0;
    rob.alloc1_phy_dest = 0; rob.alloc2_phy_dest = 0;
    rob.alloc1_old_dest = 0; rob.alloc2_old_dest = 0;
    rob.wb1_valid = 0; rob.wb2_valid = 0;
    rob.wb1_idx = 0; rob.wb2_idx = 0;
    rob.wb1_exc = 0; rob.wb2_exc = 0;
`ifdef ROB_DEBUG_PC_EN
    rob.alloc1_pc = 0; rob.alloc2_pc = 0;
`endif
  endtask

  task automatic set_alloc(input ins_t a, input ins_t b, input bit two);
    rob.alloc1_valid = 1; rob.alloc1_rf_we = a.rf_we; rob.alloc1_dest = a.dest;
    rob.alloc1_phy_dest = a.phy; rob.alloc1_old_dest = a.old;
    rob.alloc2_valid = two; rob.alloc2_rf_we = b.rf_we; rob.alloc2_dest = b.dest;
    rob.alloc2_phy_dest = b.phy; rob.alloc2_old_dest = b.old;
  endtask

  task automatic note_alloc(input ins_t a, input ins_t b, input bit two, input bit [1:0] push);
    if (push[0]) exp_q.push_back(a);
    pending.push_back(m_tail % 16);
    m_tail++;
    if (two) begin
      if (push[1]) exp_q.push_back(b);
      pending.push_back(m_tail % 16);
      m_tail++;
    end
  endtask

  task automatic set_wb1(input int idx, input bit e);
    rob.wb1_valid = 1; rob.wb1_idx = 4'(idx); rob.wb1_exc = e;
  endtask

  task automatic set_wb2(input int idx, input bit e);
    rob.wb2_valid = 1; rob.wb2_idx = 4'(idx); rob.wb2_exc = e;
  endtask

  task automatic check_idx(input string tag);
    check({tag, "_alloc1_idx"}, 32'(rob.alloc1_idx), m_tail % 16);
    check({tag, "_alloc2_idx"}, 32'(rob.alloc2_idx), (m_tail + 1) % 16);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rob_empty"},   32'(rob.rob_empty), 1);
    check({tag, "_alloc_ready"}, 32'(rob.alloc_ready), 1);
    check({tag, "_alloc1_idx"},  32'(rob.alloc1_idx), 0);
    check({tag, "_alloc2_idx"},  32'(rob.alloc2_idx), 1);
    check({tag, "_flush"},       32'(rob.flush), 0);
    check({tag, "_retire1"}, {rob.retire_inst1_valid, rob.retire_inst1_rf_we, rob.retire_inst1_dest,
                              rob.retire_inst1_phy_dest, rob.retire_inst1_old_dest}, 0);
    check({tag, "_retire2"}, {rob.retire_inst2_valid, rob.retire_inst2_rf_we, rob.retire_inst2_dest,
                              rob.retire_inst2_phy_dest, rob.retire_inst2_old_dest}, 0);
  endtask

  task automatic apply_reset();
    clear_inputs();
    resetn = 0;
    exp_q.delete();
    pending.delete();
    m_tail = 0;
    tick();
    tick();
    #2 resetn = 1;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 80; n++) begin
      if (exp_q.size() == 0 && rob.rob_empty) break;
      tick();
    end
    check({tag, "_drain_left"}, exp_q.size(), 0);
    check({tag, "_drain_empty"}, 32'(rob.rob_empty), 1);
  endtask

  task automatic mon_slot(input string tag, input logic v, input ins_t act);
    ins_t e;
    if (v) begin
      if (exp_q.size() == 0) check({tag, "_unexpected"}, act, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        check(tag, act, e);
      end
    end else begin
      check({tag, "_idle_zero"}, act, 0);
    end
  endtask

  // Monitor: compares every retire slot against the scoreboard, in slot order.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      check("retire2_without_retire1", 32'(rob.retire_inst2_valid & ~rob.retire_inst1_valid), 0);
      mon_slot("retire1", rob.retire_inst1_valid,
               {rob.retire_inst1_rf_we, rob.retire_inst1_dest, rob.retire_inst1_phy_dest, rob.retire_inst1_old_dest});
      mon_slot("retire2", rob.retire_inst2_valid,
               {rob.retire_inst2_rf_we, rob.retire_inst2_dest, rob.retire_inst2_phy_dest, rob.retire_inst2_old_dest});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t a, b, c, d, e;
    bit   go, two;
    int   k;

    clear_inputs();
    #1;
    apply_reset();
    check_reset_state("reset");

    // Reset mid-operation with retirements in flight.
    a = rnd_ins(); b = rnd_ins(); c = rnd_ins(); d = rnd_ins(); e = rnd_ins();
    set_alloc(a, b, 1); tick(); clear_inputs(); note_alloc(a, b, 1, 2'b11);
    set_alloc(c, d, 1); tick(); clear_inputs(); note_alloc(c, d, 1, 2'b00);
    set_alloc(e, e, 0); tick(); clear_inputs(); note_alloc(e, e, 0, 2'b00);
    set_wb1(0, 0); set_wb2(1, 0); tick(); clear_inputs();
    tick();
    check("mid_pre_retire1", 32'(rob.retire_inst1_valid), 1);
    check("mid_pre_retire2", 32'(rob.retire_inst2_valid), 1);
    check("mid_pre_empty", 32'(rob.rob_empty), 0);
    #2 resetn = 0;
    #1 check_reset_state("mid_reset");
    exp_q.delete(); pending.delete(); m_tail = 0;
    tick();
    #2 resetn = 1;

    // Dual allocate, dual complete.
    apply_reset();
    check_idx("dual");
    a = mk(1, 5, 34, 5); b = mk(1, 6, 35, 6);
    set_alloc(a, b, 1); tick(); clear_inputs(); note_alloc(a, b, 1, 2'b11);
    set_wb1(0, 0); set_wb2(1, 0); tick(); clear_inputs();
    check("dual_latency", 32'(rob.retire_inst1_valid), 0);
    tick();
    check("dual_retire1", 32'(rob.retire_inst1_valid), 1);
    check("dual_retire2", 32'(rob.retire_inst2_valid), 1);
    check("dual_empty", 32'(rob.rob_empty), 1);
    tick();
    check("dual_quiet", 32'(rob.retire_inst1_valid), 0);

    // Out-of-order completion.
    apply_reset();
    a = rnd_ins(); b = rnd_ins(); c = rnd_ins();
    set_alloc(a, b, 1); tick(); clear_inputs(); note_alloc(a, b, 1, 2'b11);
    check_idx("ooo");
    set_alloc(c, c, 0); tick(); clear_inputs(); note_alloc(c, c, 0, 2'b01);
    set_wb1(2, 0); tick(); clear_inputs();
    check("ooo_wait2", 32'(rob.retire_inst1_valid), 0);
    set_wb2(1, 0); tick(); clear_inputs();
    check("ooo_wait1", 32'(rob.retire_inst1_valid), 0);
    set_wb1(0, 0); tick(); clear_inputs();
    check("ooo_wait0", 32'(rob.retire_inst1_valid), 0);
    tick();
    check("ooo_pair_r1", 32'(rob.retire_inst1_valid), 1);
    check("ooo_pair_r2", 32'(rob.retire_inst2_valid), 1);
    tick();
    check("ooo_third_r1", 32'(rob.retire_inst1_valid), 1);
    check("ooo_third_r2", 32'(rob.retire_inst2_valid), 0);
    check("ooo_empty", 32'(rob.rob_empty), 1);

    // Full boundary: only the first pair is ever completed.
    apply_reset();
    for (int p = 0; p < 8; p++) begin
      check("full_ready_pre", 32'(rob.alloc_ready), 1);
      check_idx("full");
      a = rnd_ins(); b = rnd_ins();
      set_alloc(a, b, 1); tick(); clear_inputs();
      note_alloc(a, b, 1, (p == 0) ? 2'b11 : 2'b00);
    end
    check("full_ready", 32'(rob.alloc_ready), 0);
    check("full_not_empty", 32'(rob.rob_empty), 0);
    set_alloc(rnd_ins(), rnd_ins(), 1); tick(); clear_inputs();
    check_idx("full_dropped");
    set_wb1(0, 0); set_wb2(1, 0); tick(); clear_inputs();
    check("full_ready_wb", 32'(rob.alloc_ready), 0);
    tick();
    check("full_ready_after_retire", 32'(rob.alloc_ready), 1);
    check_idx("full_wrap");
    a = rnd_ins(); b = rnd_ins();
    set_alloc(a, b, 1); tick(); clear_inputs(); note_alloc(a, b, 1, 2'b00);
    check("full_again", 32'(rob.alloc_ready), 0);

    // Exception on the second entry.
    apply_reset();
    a = rnd_ins(); b = rnd_ins(); c = rnd_ins(); d = rnd_ins();
    set_alloc(a, b, 1); tick(); clear_inputs(); note_alloc(a, b, 1, 2'b01);
    set_alloc(c, d, 1); tick(); clear_inputs(); note_alloc(c, d, 1, 2'b00);
    set_wb1(1, 1); tick(); clear_inputs();
    check("exc_no_flush_yet", 32'(rob.flush), 0);
    set_wb2(0, 0); tick(); clear_inputs();
    check("exc_latency", 32'(rob.retire_inst1_valid), 0);
    tick();
    check("exc_r1", 32'(rob.retire_inst1_valid), 1);
    check("exc_r2", 32'(rob.retire_inst2_valid), 0);
    check("exc_flush_early", 32'(rob.flush), 0);
    tick();
    check("exc_flush", 32'(rob.flush), 1);
    check("exc_flush_r1", 32'(rob.retire_inst1_valid), 0);
    check("exc_flush_ready", 32'(rob.alloc_ready), 0);
    check("exc_flush_empty", 32'(rob.rob_empty), 1);
    m_tail = 0;
    pending.delete();
    set_alloc(rnd_ins(), rnd_ins(), 1); set_wb1(0, 0); tick(); clear_inputs();
    check("exc_flush_one_cycle", 32'(rob.flush), 0);
    check("exc_after_empty", 32'(rob.rob_empty), 1);
    check("exc_after_ready", 32'(rob.alloc_ready), 1);
    check_idx("exc_after");
    a = rnd_ins(); b = rnd_ins();
    set_alloc(a, b, 1); tick(); clear_inputs(); note_alloc(a, b, 1, 2'b11);
    set_wb1(0, 0); set_wb2(1, 0); tick(); clear_inputs();
    drain("exc");

    // alloc2 alone is ignored, then 20 pairs with immediate completion (wraps).
    apply_reset();
    rob.alloc2_valid = 1; tick(); clear_inputs();
    check_idx("alloc2_only");
    check("alloc2_only_empty", 32'(rob.rob_empty), 1);
    for (int i = 0; i < 20; i++) begin
      a = rnd_ins(); b = rnd_ins();
      check("wrap_ready", 32'(rob.alloc_ready), 1);
      check_idx("wrap");
      set_alloc(a, b, 1);
      if (i > 0) begin
        set_wb1((m_tail - 2) % 16, 0);
        set_wb2((m_tail - 1) % 16, 0);
      end
      tick(); clear_inputs();
      note_alloc(a, b, 1, 2'b11);
    end
    set_wb1((m_tail - 2) % 16, 0); set_wb2((m_tail - 1) % 16, 0); tick(); clear_inputs();
    drain("wrap");

    // Randomized traffic with out-of-order completion.
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      clear_inputs();
      go  = rob.alloc_ready && ($urandom_range(0, 3) != 0);
      two = 1'($urandom_range(0, 1));
      a = rnd_ins(); b = rnd_ins();
      if (go) begin
        check_idx("rand");
        set_alloc(a, b, two);
      end
      if (pending.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, pending.size() - 1);
        set_wb1(pending[k], 0); pending.delete(k);
      end
      if (pending.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, pending.size() - 1);
        set_wb2(pending[k], 0); pending.delete(k);
      end
      tick(); clear_inputs();
      if (go) note_alloc(a, b, two, 2'b11);
    end
    while (pending.size() > 0) begin
      set_wb1(pending[0], 0); pending.delete(0);
      if (pending.size() > 0) begin
        set_wb2(pending[0], 0); pending.delete(0);
      end
      tick(); clear_inputs();
    end
    drain("rand");

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer that sits opposite the rename RAT.
- Accepts up to two renamed instructions per cycle from decode/rename and collects completion reports from two writeback ports.
- Retires up to two instructions per cycle in program order, driving the RAT commit/free-list interface (retire_inst{1,2}_*).
- On an excepting head instruction, raises a one-cycle flush that restores the RAT to its commit state.

Parameters:
- DEPTH, 16: number of entries; power of two, >= 4.
- IDX_W, $clog2(DEPTH): entry index width.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- alloc1_valid / alloc2_valid  in  1  slot-1 / slot-2 allocation request; alloc2 is honoured only with alloc1.
- alloc{1,2}_rf_we  in  1  instruction writes a register.
- alloc{1,2}_dest  in  6  architectural destination (0..33, 32/33 = HI/LO).
- alloc{1,2}_phy_dest  in  6  newly mapped physical register.
- alloc{1,2}_old_dest  in  6  previous mapping.
- alloc_ready  out  1  at least 2 free entries and not flushing.
- alloc1_idx / alloc2_idx  out  IDX_W  entry index assigned (tail, tail+1).
- wb{1,2}_valid  in  1  completion report.
- wb{1,2}_idx  in  IDX_W  completing entry.
- wb{1,2}_exc  in  1  completion carries an exception.
- retire_inst{1,2}_valid  out  1  slot retires this cycle.
- retire_inst{1,2}_rf_we  out  1  retired instruction writes a register (0 when slot not valid).
- retire_inst{1,2}_dest / _old_dest / _phy_dest  out  6  retired mapping fields (0 when slot not valid).
- flush  out  1  one-cycle pipeline flush.
- rob_empty  out  1  no valid entries.

Behaviour:
- Reset (async, resetn=0): head=tail=0, all entry valid/complete/exc bits cleared; all retire_* outputs 0, flush=0, rob_empty=1, alloc_ready=1, alloc1_idx=0, alloc2_idx=1.
- Pointers: IDX_W+1 bits; the extra bit is a wrap flag. used = tail - head (IDX_W+1-bit arithmetic); full when used==DEPTH.
- alloc_ready = (DEPTH - used >= 2) && !flush.
  - Computed from registered state only; entries freed by this cycle's retirement do not count.
- Allocation: on a clock edge with alloc_ready && alloc1_valid:
  - write entry tail from slot 1 and, if alloc2_valid, entry tail+1 from slot 2;
  - set valid=1, complete=0, exc=0;
  - tail advances by 1 or 2.
  - alloc2_valid without alloc1_valid is ignored.
- Writeback: on wbN_valid, set complete[wbN_idx]=1 and exc|=wbN_exc.
  - A write to an invalid entry is ignored.
  - Both ports may target different entries in the same cycle; the same index on both ports ORs the exc bits.
  - A writeback landing in the same cycle as allocation of that index is ignored (allocation wins).
- Retire evaluation from registered state each cycle:
  - R1 = head valid & complete & !exc.
  - R2 = R1 & (head+1) valid & complete & !exc.
  - X = head valid & complete & exc.
- Retire outputs are registered, 1-cycle latency:
  - at the edge, the retire_inst1/2 registers load entry fields for R1/R2 (fields zeroed otherwise);
  - the retired entries are invalidated and head advances by R1+R2.
- Minimum completion-to-retire latency: a wb at edge k is visible at retire_* after edge k+1.
- Exception (X=1 at an edge):
  - flush register=1 for exactly the next cycle;
  - every entry is invalidated and head=tail=0;
  - no retire slot is valid that cycle, so the excepting instruction does not update commit state.
  - If slot 1 is clean and slot 2 (head+1) excepts, slot 1 retires first and the flush follows once the excepting entry reaches head.
- While flush=1: alloc_ready=0; alloc and wb inputs are ignored; nothing retires.
- Allocation and retirement in the same cycle are independent; head and tail update together.
- rob_empty = (head == tail), registered-state derived.

Optional Feature:
- Macro: ROB_DEBUG_PC_EN.
- Defined:
  - adds inputs alloc{1,2}_pc [31:0] and outputs retire_inst{1,2}_pc [31:0];
  - each entry stores the PC, driven on retire like the other fields (0 when slot not valid);
  - adds output flush_pc [31:0] = PC of the excepting entry, valid during flush.
- Undefined: these ports and the per-entry PC storage are absent; behaviour is otherwise identical.

Test Plan:
- Reset mid-operation: 5 entries live, pulse resetn low asynchronously -> immediately rob_empty=1, alloc_ready=1, all retire_* and flush 0.
- Dual alloc + dual complete:
  - stimulus: alloc (dest5,phy34,old5) and (dest6,phy35,old6) -> idx 0,1; wb1=0 and wb2=1 the next cycle.
  - response: one cycle later both retire valid with exact fields, then rob_empty=1.
- Out-of-order completion:
  - stimulus: alloc idx 0,1,2; complete 2, then 1, then 0.
  - response: no retire until idx0 completes; then idx0+idx1 retire together; idx2 retires the next cycle.
- Full boundary (DEPTH=16):
  - 7 pairs allocated -> alloc_ready=1;
  - 8th pair -> used=16, alloc_ready=0 and further requests dropped;
  - two entries retire -> alloc_ready=1 the following cycle.
- Exception:
  - stimulus: alloc 4; wb idx1 exc=1; wb idx0.
  - response: idx0 retires, next cycle flush=1 for 1 cycle with no retire valid; then rob_empty=1 and alloc1_idx=0.
- Wrap-around: stream 20 pairs with immediate completion -> indices wrap 15->0, retire order and fields match allocation order exactly, never more than 2 retires per cycle.
